// File: rtl/tdc_seq_pkg.sv
// Shared types and constants for the TDC delay-sweep sequencer.
package tdc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SHOT,
    ST_NEXT,
    ST_FIN
  } state_t;

  localparam int unsigned DEF_CNT_W   = 16;
  localparam int unsigned DEF_REP_W   = 8;
  localparam int unsigned DEF_PULSE_W = 4;
  localparam int unsigned DEF_GAP     = 1000;

  localparam int unsigned LED_W        = 5;
  localparam int unsigned LED_BUSY_BIT = 4;
  localparam int unsigned LED_IDX_MSB  = 3;

endpackage

// File: rtl/tdc_sweep_sequencer_if.sv
// Configuration and TDC-side pulse/status bundle of the sweep sequencer.
interface tdc_sweep_sequencer_if
  import tdc_seq_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned REP_W = DEF_REP_W
);
  logic [CNT_W-1:0] cfg_dly_start;
  logic [CNT_W-1:0] cfg_dly_step;
  logic [CNT_W-1:0] cfg_steps;
  logic [REP_W-1:0] cfg_repeat;
  logic             teststart;
  logic             teststop;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] step_idx;
  logic [LED_W-1:0] led;

  modport master (
    output cfg_dly_start, cfg_dly_step, cfg_steps, cfg_repeat,
    input  teststart, teststop, busy, done, step_idx, led
  );

  modport slave (
    input  cfg_dly_start, cfg_dly_step, cfg_steps, cfg_repeat,
    output teststart, teststop, busy, done, step_idx, led
  );
endinterface

// File: rtl/sync_fedge.sv
// Two-flop synchroniser for an active-low async input with a registered
// one-cycle pulse on its falling edge.
module sync_fedge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall_p
);
  logic s1, s2, s3;

  // Flops idle high so reset release never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s3     <= 1'b1;
      fall_p <= 1'b0;
    end else begin
      s1     <= din;
      s2     <= s1;
      s3     <= s2;
      fall_p <= s3 & ~s2;
    end
  end
endmodule

// File: rtl/tdc_sweep_sequencer.sv
// Steps the TDC start/stop pulse generator through a programmable delay
// sweep, firing a fixed number of start/stop pairs per delay value.
module tdc_sweep_sequencer
  import tdc_seq_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned REP_W   = DEF_REP_W,
  parameter int unsigned PULSE_W = DEF_PULSE_W,
  parameter int unsigned GAP     = DEF_GAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trig_n,
  input  logic                  abort_n,
  tdc_sweep_sequencer_if.slave  bus
);
  localparam int unsigned T_W = CNT_W + 2;

  state_t           state, state_n;
  logic [T_W-1:0]   t, t_n;
  logic [CNT_W-1:0] dly, dly_n;
  logic [CNT_W-1:0] step_r, step_n;
  logic [CNT_W-1:0] steps_r, steps_n;
  logic [CNT_W-1:0] idx, idx_n;
  logic [REP_W-1:0] rmax, rmax_n;
  logic [REP_W-1:0] rep, rep_n;

  logic trig_p;
  logic ab1, ab2;
  logic abort;

  logic [T_W-1:0]   dly_x, shot_end, stop_end;
  logic [REP_W:0]   rep_inc;
  logic [CNT_W:0]   idx_inc;
  logic             in_run, in_shot;
  logic             start_c, stop_c, busy_c, done_c;
  logic [LED_W-1:0] led_c;

  sync_fedge u_trig (
    .clk    (clk),
    .rst    (rst),
    .din    (trig_n),
    .fall_p (trig_p)
  );

  // Abort is a level, so it only needs the synchroniser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ab1 <= 1'b1;
      ab2 <= 1'b1;
    end else begin
      ab1 <= abort_n;
      ab2 <= ab1;
    end
  end
  assign abort = ~ab2;

  assign dly_x    = T_W'(dly);
  assign shot_end = dly_x + T_W'(PULSE_W + GAP - 1);
  assign stop_end = dly_x + T_W'(PULSE_W);
  assign rep_inc  = (REP_W+1)'(rep) + (REP_W+1)'(1);
  assign idx_inc  = (CNT_W+1)'(idx) + (CNT_W+1)'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      t       <= '0;
      dly     <= '0;
      step_r  <= '0;
      steps_r <= '0;
      idx     <= '0;
      rmax    <= '0;
      rep     <= '0;
    end else begin
      state   <= state_n;
      t       <= t_n;
      dly     <= dly_n;
      step_r  <= step_n;
      steps_r <= steps_n;
      idx     <= idx_n;
      rmax    <= rmax_n;
      rep     <= rep_n;
    end
  end

  always_comb begin
    state_n = state;
    t_n     = t;
    dly_n   = dly;
    step_n  = step_r;
    steps_n = steps_r;
    idx_n   = idx;
    rmax_n  = rmax;
    rep_n   = rep;
    if (abort) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (trig_p) state_n = ST_ARM;
        ST_ARM: begin
          dly_n   = bus.cfg_dly_start;
          step_n  = bus.cfg_dly_step;
          steps_n = (bus.cfg_steps == '0) ? CNT_W'(1) : bus.cfg_steps;
          rmax_n  = (bus.cfg_repeat == '0) ? REP_W'(1) : bus.cfg_repeat;
          idx_n   = '0;
          rep_n   = '0;
          t_n     = '0;
          state_n = ST_SHOT;
        end
        ST_SHOT: begin
          if (t == shot_end) state_n = ST_NEXT;
          else               t_n     = t + T_W'(1);
        end
        ST_NEXT: begin
          t_n = '0;
          if (rep_inc < (REP_W+1)'(rmax)) begin
            rep_n   = REP_W'(rep_inc);
            state_n = ST_SHOT;
          end else if (idx_inc < (CNT_W+1)'(steps_r)) begin
            idx_n   = CNT_W'(idx_inc);
            dly_n   = dly + step_r;
            rep_n   = '0;
            state_n = ST_SHOT;
          end else begin
            state_n = ST_FIN;
          end
        end
        ST_FIN:  state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Output terms evaluated from the current state/t, then registered.
  always_comb begin
    in_run  = (state == ST_ARM) || (state == ST_SHOT) || (state == ST_NEXT);
    in_shot = (state == ST_SHOT) && !abort;
    start_c = in_shot && (t < T_W'(PULSE_W));
    stop_c  = in_shot && (t >= dly_x) && (t < stop_end);
    busy_c  = in_run && !abort;
    done_c  = (state == ST_FIN) && !abort;
    led_c   = '0;
    led_c[LED_BUSY_BIT]  = busy_c;
    led_c[LED_IDX_MSB:0] = idx[LED_IDX_MSB:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.teststart <= 1'b0;
      bus.teststop  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.step_idx  <= '0;
      bus.led       <= '0;
    end else begin
      bus.teststart <= start_c;
      bus.teststop  <= stop_c;
      bus.busy      <= busy_c;
      bus.done      <= done_c;
      bus.step_idx  <= idx;
      bus.led       <= led_c;
    end
  end
endmodule

// File: tb/tb_tdc_sweep_sequencer.sv
// Directed self-checking bench for tdc_sweep_sequencer.
module tb_tdc_sweep_sequencer;
  logic clk;
  logic rst;
  logic trig_n;
  logic abort_n;
  int   cyc;
  int   trig_cyc;
  int   n_vec;
  int   n_err;
  int   exp_sep [8] = '{2, 2, 5, 5, 8, 8, 11, 11};
  int   exp_idx [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  int start_q[$], sfall_q[$], stop_q[$], ovl_q[$], done_q[$], bfall_q[$];
  int idx_q[$], led_q[$];
  logic p_start, p_stop, p_busy;

  tdc_sweep_sequencer_if #(.CNT_W(16), .REP_W(8)) bus ();

  tdc_sweep_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .trig_n  (trig_n),
    .abort_n (abort_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: timestamps of edges seen at the falling clock edge.
  always @(negedge clk) begin
    if (bus.teststart === 1'b1 && p_start === 1'b0) begin
      start_q.push_back(cyc);
      idx_q.push_back(int'(bus.step_idx));
      led_q.push_back(int'(bus.led));
    end
    if (bus.teststart === 1'b0 && p_start === 1'b1) sfall_q.push_back(cyc);
    if (bus.teststop === 1'b1 && p_stop === 1'b0) begin
      stop_q.push_back(cyc);
      ovl_q.push_back(int'(bus.teststart));
    end
    if (bus.done === 1'b1) done_q.push_back(cyc);
    if (bus.busy === 1'b0 && p_busy === 1'b1) bfall_q.push_back(cyc);
    p_start = bus.teststart;
    p_stop  = bus.teststop;
    p_busy  = bus.busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_q();
    start_q.delete(); sfall_q.delete(); stop_q.delete(); ovl_q.delete();
    done_q.delete(); bfall_q.delete(); idx_q.delete(); led_q.delete();
  endtask

  task automatic set_cfg(input int st, input int sp, input int ns, input int nr);
    bus.cfg_dly_start = 16'(st);
    bus.cfg_dly_step  = 16'(sp);
    bus.cfg_steps     = 16'(ns);
    bus.cfg_repeat    = 8'(nr);
  endtask

  task automatic pulse_trig(input int width);
    @(negedge clk);
    trig_n   = 1'b0;
    trig_cyc = cyc;
    repeat (width) @(negedge clk);
    trig_n = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k = 0;
    int n0 = done_q.size();
    while (done_q.size() == n0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(done_q.size() > n0), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_starts(input string tag, input int n, input int bound);
    int k = 0;
    while (start_q.size() < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(start_q.size() >= n), 32'd1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    p_start = 1'b0; p_stop = 1'b0; p_busy = 1'b0;
    trig_n = 1'b1; abort_n = 1'b1;
    set_cfg(0, 0, 0, 0);
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_teststart", 32'(bus.teststart), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_led",       32'(bus.led),       32'd0);
    @(negedge clk) rst = 1'b1;

    // Reset asserted mid-shot while teststart is high.
    set_cfg(10, 0, 1, 1);
    clear_q();
    pulse_trig(3);
    wait_starts("rst_shot_start", 1, 20);
    check("rst_pre_start_high", 32'(bus.teststart), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_teststart", 32'(bus.teststart), 32'd0);
    check("rst_mid_busy",      32'(bus.busy),      32'd0);
    check("rst_mid_done",      32'(bus.done),      32'd0);
    check("rst_mid_stepidx",   32'(bus.step_idx),  32'd0);
    check("rst_mid_led",       32'(bus.led),       32'd0);
    @(negedge clk) rst = 1'b1;
    #1 clear_q();
    repeat (50) @(negedge clk);
    check("rst_no_pulses", 32'(start_q.size() + stop_q.size() + done_q.size()), 32'd0);

    // Single shot, 100 ns trigger press.
    clear_q();
    pulse_trig(10);
    wait_done("single_done_seen", 1200);
    check("single_latency_ok", 32'((start_q[0] - trig_cyc) >= 4 && (start_q[0] - trig_cyc) <= 6), 32'd1);
    check("single_starts",  32'(start_q.size()), 32'd1);
    check("single_width",   32'(sfall_q[0] - start_q[0]), 32'd4);
    check("single_sep",     32'(stop_q[0] - start_q[0]), 32'd10);
    check("single_done_at", 32'(done_q[0] - start_q[0]), 32'd1015);
    check("single_dones",   32'(done_q.size()), 32'd1);
    check("single_busy_fall", 32'(bfall_q[0]), 32'(done_q[0]));

    // Four-step sweep, two shots per step.
    set_cfg(2, 3, 4, 2);
    clear_q();
    pulse_trig(3);
    wait_done("sweep_done_seen", 9000);
    check("sweep_starts", 32'(start_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("sweep_sep%0d", i), 32'(stop_q[i] - start_q[i]), 32'(exp_sep[i]));
      check($sformatf("sweep_idx%0d", i), 32'(idx_q[i]), 32'(exp_idx[i]));
      check($sformatf("sweep_led%0d", i), 32'(led_q[i]), 32'(16 + exp_idx[i]));
    end
    check("sweep_period", 32'(start_q[1] - start_q[0]), 32'd1007);
    check("sweep_dones",  32'(done_q.size()), 32'd1);
    check("sweep_idx_hold", 32'(bus.step_idx), 32'd3);
    check("sweep_led_end",  32'(bus.led), 32'd3);

    // Zero delay: both edges in the same cycle.
    set_cfg(0, 0, 1, 1);
    clear_q();
    pulse_trig(3);
    wait_done("zero_done_seen", 1200);
    check("zero_sep", 32'(stop_q[0] - start_q[0]), 32'd0);

    // Overlapping pulses; zero steps/repeat run exactly one shot.
    set_cfg(2, 7, 0, 0);
    clear_q();
    pulse_trig(2);
    wait_done("ovl_done_seen", 1200);
    check("ovl_starts",  32'(start_q.size()), 32'd1);
    check("ovl_sep",     32'(stop_q[0] - start_q[0]), 32'd2);
    check("ovl_overlap", 32'(ovl_q[0]), 32'd1);

    // Delay accumulator wraps silently.
    set_cfg(16'hFFFF, 1, 2, 1);
    clear_q();
    pulse_trig(3);
    wait_done("wrap_done_seen", 70000);
    check("wrap_starts", 32'(start_q.size()), 32'd2);
    check("wrap_sep0",   32'(stop_q[0] - start_q[0]), 32'd65535);
    check("wrap_sep1",   32'(stop_q[1] - start_q[1]), 32'd0);

    // Retrigger during a shot is ignored.
    set_cfg(10, 0, 1, 2);
    clear_q();
    pulse_trig(3);
    wait_starts("retrig_first", 1, 20);
    pulse_trig(3);
    wait_done("retrig_done_seen", 2200);
    check("retrig_starts", 32'(start_q.size()), 32'd2);
    check("retrig_period", 32'(start_q[1] - start_q[0]), 32'd1015);
    check("retrig_dones",  32'(done_q.size()), 32'd1);

    // Abort mid-sweep, trigger while aborted, then a fresh sweep.
    set_cfg(10, 5, 4, 1);
    clear_q();
    pulse_trig(3);
    wait_starts("abort_second", 2, 2200);
    repeat (5) @(negedge clk);
    abort_n = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy",      32'(bus.busy),      32'd0);
    check("abort_teststart", 32'(bus.teststart), 32'd0);
    check("abort_teststop",  32'(bus.teststop),  32'd0);
    check("abort_idx_hold",  32'(bus.step_idx),  32'd1);
    check("abort_led",       32'(bus.led),       32'd1);
    pulse_trig(3);
    repeat (30) @(negedge clk);
    check("abort_trig_ignored", 32'(start_q.size()), 32'd2);
    abort_n = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_done", 32'(done_q.size()), 32'd0);
    check("abort_no_restart", 32'(start_q.size()), 32'd2);
    set_cfg(3, 0, 1, 1);
    clear_q();
    pulse_trig(3);
    wait_done("fresh_done_seen", 1200);
    check("fresh_idx",   32'(idx_q[0]), 32'd0);
    check("fresh_sep",   32'(stop_q[0] - start_q[0]), 32'd3);
    check("fresh_dones", 32'(done_q.size()), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
